// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared ALU, memory port and register file.
module multicycle_control #(
    parameter int unsigned STRICT_FUNCT3 = 1,
    parameter int unsigned MEM_TIMEOUT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        Iformat,
    output logic        LW,
    output logic        SW,
    output logic        BEQ,
    output logic        JAL,
    output logic        JALR,
    output logic        trap,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wait;

    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic        w_f3_010;
    logic        w_f3_000;
    logic        w_in_mem;
    logic        w_mem_wait;
    logic        w_timeout;
    logic        w_unused_instr;

    assign w_op           = instr[6:0];
    assign w_f3           = instr[14:12];
    assign w_unused_instr = ^{instr[31:15], instr[11:7]};
    assign w_f3_010       = (STRICT_FUNCT3 == 0) || (w_f3 == 3'b010);
    assign w_f3_000       = (STRICT_FUNCT3 == 0) || (w_f3 == 3'b000);

    // A cycle counts toward the timeout only while a request is outstanding and unanswered.
    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_mem_wait = w_in_mem && !mem_ready;
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait && (r_wait == MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_mem_wait && (MEM_TIMEOUT != 0)) ? r_wait + 32'd1 : '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        trap      = 1'b0;
        state     = '0;
        if (!reset) begin
            state = r_state;
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        alu_src_b = 2'd1;
                        pc_write  = 1'b1;
                        w_next    = S_DECODE;
                    end else if (w_timeout) begin
                        w_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd2;
                    case (w_op)
                        OP_R:    w_next = S_EXEC_R;
                        OP_IMM:  w_next = S_EXEC_I;
                        OP_LW,
                        OP_SW:   w_next = w_f3_010 ? S_MEM_ADDR : S_TRAP;
                        OP_BEQ:  w_next = w_f3_000 ? S_BRANCH : S_TRAP;
                        OP_JAL:  w_next = S_JAL;
                        OP_JALR: w_next = w_f3_000 ? S_JALR : S_TRAP;
                        default: w_next = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a = 2'd1;
                    alu_op    = 2'd2;
                    w_next    = S_WB_ALU;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    alu_op    = 2'd2;
                    w_next    = S_WB_ALU;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    w_next    = instr[5] ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready)      w_next = S_WB_MEM;
                    else if (w_timeout) w_next = S_TRAP;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready)      w_next = S_FETCH;
                    else if (w_timeout) w_next = S_TRAP;
                end
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd1;
                    w_next    = S_FETCH;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                    w_next    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'd1;
                    alu_op    = 2'd1;
                    pc_write  = alu_zero;
                    pc_src    = 2'd1;
                    w_next    = S_FETCH;
                end
                S_JAL: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_src    = 2'd1;
                    w_next    = S_FETCH;
                end
                S_JALR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_src    = 2'd2;
                    w_next    = S_FETCH;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: w_next = S_TRAP;
            endcase
        end
    end

    // Immediate-format selects are only meaningful once IR holds the instruction.
    always_comb begin
        Iformat = 1'b0;
        LW      = 1'b0;
        SW      = 1'b0;
        BEQ     = 1'b0;
        JAL     = 1'b0;
        JALR    = 1'b0;
        if (!reset && (r_state != S_FETCH) && (r_state != S_TRAP)) begin
            case (w_op)
                OP_IMM:  Iformat = 1'b1;
                OP_LW:   LW      = 1'b1;
                OP_SW:   SW      = 1'b1;
                OP_BEQ:  BEQ     = 1'b1;
                OP_JAL:  JAL     = 1'b1;
                OP_JALR: JALR    = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each supported instruction class,
// memory wait states, reset mid-transaction, illegal opcodes and the memory timeout.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
    logic        Iformat, LW, SW, BEQ, JAL, JALR, trap;
    logic [3:0]  state;

    logic [15:0] w_ctrl;
    logic [5:0]  w_imm;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control #(.STRICT_FUNCT3(1), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .Iformat(Iformat), .LW(LW), .SW(SW), .BEQ(BEQ), .JAL(JAL), .JALR(JALR),
        .trap(trap), .state(state)
    );

    assign w_ctrl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     reg_write, wb_sel, alu_src_a, alu_src_b, alu_op};
    assign w_imm  = {Iformat, LW, SW, BEQ, JAL, JALR};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] c(input logic mreq, input logic we, input logic io,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wb, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op);
        return {mreq, we, io, irw, pcw, pcs, rw, wb, a, b, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] st,
                              input logic [15:0] ct, input logic [5:0] im);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, st});
        chk({tag, ".ctrl"},  {16'd0, w_ctrl}, {16'd0, ct});
        chk({tag, ".imm"},   {26'd0, w_imm},  {26'd0, im});
        chk({tag, ".trap"},  {31'd0, trap},   {31'd0, (st == 4'd12)});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] C_FETCH_RDY, C_FETCH_WAIT, C_DEC, C_NONE;

    initial begin
        C_FETCH_RDY  = c(1,0,0,1,1,2'd0,0,2'd0,2'd0,2'd1,2'd0);
        C_FETCH_WAIT = c(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0);
        C_DEC        = c(0,0,0,0,0,2'd0,0,2'd0,2'd2,2'd2,2'd0);
        C_NONE       = '0;

        reset = 1'b1; instr = '0; mem_ready = 1'b0; alu_zero = 1'b0;
        tick; tick;
        expect_all("reset", 4'd0, C_NONE, 6'b000000);

        // ADDI x1,x0,5 with memory always ready
        instr = 32'h00500093; mem_ready = 1'b1; reset = 1'b0; #1;
        expect_all("addi_fetch", 4'd0, C_FETCH_RDY, 6'b000000);
        tick; expect_all("addi_dec", 4'd1, C_DEC, 6'b100000);
        tick; expect_all("addi_exec", 4'd3, c(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd2,2'd2), 6'b100000);
        tick; expect_all("addi_wb", 4'd8, c(0,0,0,0,0,2'd0,1,2'd0,2'd0,2'd0,2'd0), 6'b100000);
        tick; expect_all("addi_fetch2", 4'd0, C_FETCH_RDY, 6'b000000);

        // ADD x3,x1,x2
        instr = 32'h002081B3;
        tick; expect_all("add_dec", 4'd1, C_DEC, 6'b000000);
        tick; expect_all("add_exec", 4'd2, c(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd0,2'd2), 6'b000000);
        tick; expect_all("add_wb", 4'd8, c(0,0,0,0,0,2'd0,1,2'd0,2'd0,2'd0,2'd0), 6'b000000);
        tick;

        // LW with three wait cycles in MEM_RD
        instr = 32'h0040A103;
        tick; expect_all("lw_dec", 4'd1, C_DEC, 6'b010000);
        tick; expect_all("lw_addr", 4'd4, c(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd2,2'd0), 6'b010000);
        mem_ready = 1'b0;
        tick; expect_all("lw_rd1", 4'd5, c(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b010000);
        tick; expect_all("lw_rd2", 4'd5, c(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b010000);
        tick; expect_all("lw_rd3", 4'd5, c(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b010000);
        tick; mem_ready = 1'b1; #1;
        expect_all("lw_rd4", 4'd5, c(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b010000);
        tick; expect_all("lw_wb", 4'd7, c(0,0,0,0,0,2'd0,1,2'd1,2'd0,2'd0,2'd0), 6'b010000);
        tick; expect_all("lw_fetch", 4'd0, C_FETCH_RDY, 6'b000000);

        // BEQ taken then not taken within the same BRANCH cycle
        instr = 32'h00208463; alu_zero = 1'b1;
        tick; expect_all("beq_dec", 4'd1, C_DEC, 6'b000100);
        tick; expect_all("beq_taken", 4'd9, c(0,0,0,0,1,2'd1,0,2'd0,2'd1,2'd0,2'd1), 6'b000100);
        alu_zero = 1'b0; #1;
        expect_all("beq_not", 4'd9, c(0,0,0,0,0,2'd1,0,2'd0,2'd1,2'd0,2'd1), 6'b000100);
        tick;

        // JAL
        instr = 32'h0000006F;
        tick; expect_all("jal_dec", 4'd1, C_DEC, 6'b000010);
        tick; expect_all("jal_ex", 4'd10, c(0,0,0,0,1,2'd1,1,2'd2,2'd0,2'd0,2'd0), 6'b000010);
        tick;

        // JALR
        instr = 32'h000080E7;
        tick; expect_all("jalr_dec", 4'd1, C_DEC, 6'b000001);
        tick; expect_all("jalr_ex", 4'd11, c(0,0,0,0,1,2'd2,1,2'd2,2'd1,2'd2,2'd0), 6'b000001);
        tick; expect_all("jalr_fetch", 4'd0, C_FETCH_RDY, 6'b000000);

        // SW stalled in MEM_WR, then reset mid-transaction
        instr = 32'h0020A223;
        tick; expect_all("sw_dec", 4'd1, C_DEC, 6'b001000);
        tick; expect_all("sw_addr", 4'd4, c(0,0,0,0,0,2'd0,0,2'd0,2'd1,2'd2,2'd0), 6'b001000);
        mem_ready = 1'b0;
        tick; expect_all("sw_wr1", 4'd6, c(1,1,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b001000);
        tick; expect_all("sw_wr2", 4'd6, c(1,1,1,0,0,2'd0,0,2'd0,2'd0,2'd0,2'd0), 6'b001000);
        reset = 1'b1; #1;
        expect_all("sw_rst_now", 4'd0, C_NONE, 6'b000000);
        tick; expect_all("sw_rst_edge", 4'd0, C_NONE, 6'b000000);
        reset = 1'b0; #1;
        expect_all("rst_fetch", 4'd0, C_FETCH_WAIT, 6'b000000);

        // Seven unanswered FETCH cycles, ready on the eighth: no timeout
        for (int i = 0; i < 7; i++) begin
            tick; expect_all("fetch_wait", 4'd0, C_FETCH_WAIT, 6'b000000);
        end
        mem_ready = 1'b1; instr = 32'hFFFFFFFF; #1;
        expect_all("fetch_ready8", 4'd0, C_FETCH_RDY, 6'b000000);

        // Illegal opcode traps after DECODE and stays trapped
        tick; expect_all("ill_dec", 4'd1, C_DEC, 6'b000000);
        tick; expect_all("ill_trap", 4'd12, C_NONE, 6'b000000);
        for (int i = 0; i < 20; i++) begin
            mem_ready = ~mem_ready;
            tick; expect_all("trap_hold", 4'd12, C_NONE, 6'b000000);
        end
        reset = 1'b1; tick; reset = 1'b0; mem_ready = 1'b0; #1;
        expect_all("trap_clear", 4'd0, C_FETCH_WAIT, 6'b000000);

        // Eight unanswered FETCH cycles: timeout trap
        for (int i = 0; i < 7; i++) begin
            tick; expect_all("to_wait", 4'd0, C_FETCH_WAIT, 6'b000000);
        end
        tick; expect_all("to_trap", 4'd12, C_NONE, 6'b000000);

        // LW with funct3=000 is rejected under strict decode
        reset = 1'b1; tick; reset = 1'b0; mem_ready = 1'b1; instr = 32'h00008103; #1;
        expect_all("f3_fetch", 4'd0, C_FETCH_RDY, 6'b000000);
        tick; expect_all("f3_dec", 4'd1, C_DEC, 6'b010000);
        tick; expect_all("f3_trap", 4'd12, C_NONE, 6'b000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
